dcache_write_buffer: RTL



---
 rtl/cache_axi_pkg.sv | 17 +
 rtl/dcache_write_buffer_if.sv | 48 ++++
 rtl/wb_addr_cam.sv | 39 +++
 rtl/dcache_write_buffer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cache_axi_pkg.sv
// Shared definitions for the dcache write path and Cache_AXI_switch:
// write types, line geometry and the drain state encoding.
package cache_axi_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = 32 - OFFSET_W;

  localparam logic [2:0] WR_TYPE_LINE = 3'b100;
  localparam logic [2:0] WR_TYPE_WORD = 3'b010;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_BUSY = 1'b1
  } drain_state_t;

endpackage

// File: rtl/dcache_write_buffer_if.sv
// Bundles for the write buffer: dcache push/query side and switch drain side.
// On each bundle the master is the side that drives the request.
interface wb_push_if #(
  parameter int LINE_W = cache_axi_pkg::LINE_W
);
  logic              push_valid;
  logic              push_ready;
  logic [2:0]        push_type;
  logic [31:0]       push_addr;
  logic [3:0]        push_wstrb;
  logic [LINE_W-1:0] push_data;
  logic [31:0]       query_addr;
  logic              query_hit;
  logic [LINE_W-1:0] query_data;
  logic              query_conflict;
  logic              wb_empty;

  modport master (
    output push_valid, push_type, push_addr, push_wstrb, push_data, query_addr,
    input  push_ready, query_hit, query_data, query_conflict, wb_empty
  );

  modport slave (
    input  push_valid, push_type, push_addr, push_wstrb, push_data, query_addr,
    output push_ready, query_hit, query_data, query_conflict, wb_empty
  );
endinterface

interface wb_drain_if #(
  parameter int LINE_W = cache_axi_pkg::LINE_W
);
  logic              d_wr_req_o;
  logic [2:0]        d_wr_type_o;
  logic [31:0]       d_wr_addr_o;
  logic [3:0]        d_wr_wstrb_o;
  logic [LINE_W-1:0] d_wr_data_o;
  logic              d_wr_finish_i;

  modport master (
    output d_wr_req_o, d_wr_type_o, d_wr_addr_o, d_wr_wstrb_o, d_wr_data_o,
    input  d_wr_finish_i
  );

  modport slave (
    input  d_wr_req_o, d_wr_type_o, d_wr_addr_o, d_wr_wstrb_o, d_wr_data_o,
    output d_wr_finish_i
  );
endinterface

// File: rtl/wb_addr_cam.sv
// Line-tag CAM over the write-buffer entries with age-priority select:
// newest_idx is the youngest matching line entry counting from oldest_idx.
module wb_addr_cam #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int TAG_W = cache_axi_pkg::TAG_W
) (
  input  logic [TAG_W-1:0] entry_tag [DEPTH],
  input  logic [DEPTH-1:0] entry_valid,
  input  logic [DEPTH-1:0] entry_line,
  input  logic [PTR_W-1:0] oldest_idx,
  input  logic [TAG_W-1:0] match_tag,
  output logic [DEPTH-1:0] hit_vec,
  output logic             line_hit,
  output logic             word_hit,
  output logic [PTR_W-1:0] newest_idx
);

  logic [DEPTH-1:0] line_match;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign hit_vec[gi] = entry_valid[gi] && (entry_tag[gi] == match_tag);
  end

  assign line_match = hit_vec & entry_line;
  assign line_hit   = |line_match;
  assign word_hit   = |(hit_vec & ~entry_line);

  // Walk from oldest to youngest so the last match seen is the newest.
  always_comb begin
    newest_idx = oldest_idx;
    for (int age = 0; age < DEPTH; age++) begin
      if (line_match[oldest_idx + PTR_W'(age)]) begin
        newest_idx = oldest_idx + PTR_W'(age);
      end
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted write buffer between the dcache and the AXI switch: queues line
// evictions and word stores, coalesces same-line evictions, drains in order.
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = cache_axi_pkg::LINE_W
) (
  input logic        clk,
  input logic        reset,
  wb_push_if.slave   push,
  wb_drain_if.master drain
);
  import cache_axi_pkg::OFFSET_W;
  import cache_axi_pkg::TAG_W;
  import cache_axi_pkg::WR_TYPE_LINE;
  import cache_axi_pkg::drain_state_t;
  import cache_axi_pkg::DRAIN_IDLE;
  import cache_axi_pkg::DRAIN_BUSY;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid_reg;
  logic [2:0]        type_reg  [DEPTH];
  logic [31:0]       addr_reg  [DEPTH];
  logic [3:0]        wstrb_reg [DEPTH];
  logic [LINE_W-1:0] data_reg  [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  drain_state_t     state_reg, state_next;

  logic [TAG_W-1:0] entry_tag [DEPTH];
  logic [DEPTH-1:0] entry_line;
  logic [DEPTH-1:0] in_flight;
  logic [DEPTH-1:0] merge_ok;

  logic busy, pop;
  logic push_is_line, coalesce, ready;
  logic push_fire, push_alloc, push_merge;

  logic             q_line_hit, q_word_hit;
  logic [PTR_W-1:0] q_newest_idx;
  logic [DEPTH-1:0] q_hit_unused;
  logic             c_line_hit, c_word_unused;
  logic [PTR_W-1:0] c_idx;
  logic [DEPTH-1:0] c_hit_unused;
  logic [OFFSET_W-1:0] query_offset_unused;

  assign busy = (state_reg == DRAIN_BUSY);
  assign query_offset_unused = push.query_addr[OFFSET_W-1:0];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry_tag[gi]  = addr_reg[gi][31:OFFSET_W];
    assign entry_line[gi] = (type_reg[gi] == WR_TYPE_LINE);
    assign in_flight[gi]  = busy && (head_reg == PTR_W'(gi));
  end

  // The entry on the bus is frozen; only queued lines may absorb a rewrite.
  assign merge_ok = valid_reg & ~in_flight;

  wb_addr_cam #(.DEPTH(DEPTH), .PTR_W(PTR_W), .TAG_W(TAG_W)) u_query_cam (
    .entry_tag   (entry_tag),
    .entry_valid (valid_reg),
    .entry_line  (entry_line),
    .oldest_idx  (head_reg),
    .match_tag   (push.query_addr[31:OFFSET_W]),
    .hit_vec     (q_hit_unused),
    .line_hit    (q_line_hit),
    .word_hit    (q_word_hit),
    .newest_idx  (q_newest_idx)
  );

  wb_addr_cam #(.DEPTH(DEPTH), .PTR_W(PTR_W), .TAG_W(TAG_W)) u_merge_cam (
    .entry_tag   (entry_tag),
    .entry_valid (merge_ok),
    .entry_line  (entry_line),
    .oldest_idx  (head_reg),
    .match_tag   (push.push_addr[31:OFFSET_W]),
    .hit_vec     (c_hit_unused),
    .line_hit    (c_line_hit),
    .word_hit    (c_word_unused),
    .newest_idx  (c_idx)
  );

  assign push_is_line = (push.push_type == WR_TYPE_LINE);
  assign coalesce     = push_is_line && c_line_hit;
  assign ready        = (count_reg < CNT_W'(DEPTH)) || coalesce;
  assign push_fire    = push.push_valid && ready;
  assign push_alloc   = push_fire && !coalesce;
  assign push_merge   = push_fire && coalesce;
  assign pop          = busy && drain.d_wr_finish_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DRAIN_IDLE: if (count_reg != '0) state_next = DRAIN_BUSY;
      DRAIN_BUSY: if (drain.d_wr_finish_i) state_next = DRAIN_IDLE;
      default:    state_next = DRAIN_IDLE;
    endcase
  end

  always_comb begin
    head_next  = head_reg + PTR_W'(pop);
    tail_next  = tail_reg + PTR_W'(push_alloc);
    count_next = count_reg + CNT_W'(push_alloc) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= DRAIN_IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Allocation never lands on the popping head: that would need a full buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_reg[i]  <= '0;
        addr_reg[i]  <= '0;
        wstrb_reg[i] <= '0;
        data_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_alloc && (tail_reg == PTR_W'(i))) begin
          valid_reg[i] <= 1'b1;
          type_reg[i]  <= push.push_type;
          addr_reg[i]  <= push.push_addr;
          wstrb_reg[i] <= push_is_line ? 4'hF : push.push_wstrb;
          data_reg[i]  <= push.push_data;
        end else if (push_merge && (c_idx == PTR_W'(i))) begin
          data_reg[i] <= push.push_data;
        end else if (pop && (head_reg == PTR_W'(i))) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign push.push_ready     = ready;
  assign push.query_hit      = q_line_hit;
  assign push.query_data     = q_line_hit ? data_reg[q_newest_idx] : '0;
  assign push.query_conflict = q_word_hit;
  assign push.wb_empty       = (count_reg == '0) && !busy;

  assign drain.d_wr_req_o   = busy;
  assign drain.d_wr_type_o  = busy ? type_reg[head_reg]  : '0;
  assign drain.d_wr_addr_o  = busy ? addr_reg[head_reg]  : '0;
  assign drain.d_wr_wstrb_o = busy ? wstrb_reg[head_reg] : '0;
  assign drain.d_wr_data_o  = busy ? data_reg[head_reg]  : '0;

endmodule
